alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIRST_PRI, default 0: requester (0 or 1) that wins a simultaneous request after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 Req0 / Req1  input  1 each  request from requester 0 / 1.
REQ-005 SrcA0, SrcB0 / SrcA1, SrcB1  input  32 each  operands from requester 0 / 1.
REQ-006 AluControl0 / AluControl1  input  3 each  ALU operation code from requester 0 / 1.
REQ-007 Gnt0 / Gnt1  output  1 each  registered one-cycle acceptance pulse.
REQ-008 Valid0 / Valid1  output  1 each  registered one-cycle result-valid pulse.
REQ-009 Result0 / Result1  output  32 each  last completed result per requester.
REQ-010 SrcA, SrcB  output  32 each  registered operands driven to the shared ALU.
REQ-011 AluControl  output  3  registered op code driven to the shared ALU.
REQ-012 AluResult  input  32  combinational result from the shared ALU.
REQ-013 Busy  output  1  high while state is EXEC.

Function
REQ-014 FSM states SHALL be IDLE and EXEC only.
REQ-015 In IDLE with no Req at a clock edge: remain IDLE, no outputs change.
REQ-016 In IDLE with exactly one Req high at edge N, that requester SHALL be selected.
REQ-017 In IDLE with both Req high at edge N: the requester not granted most recently wins; after reset FIRST_PRI wins.
REQ-018 At edge N the selected requester's SrcA/SrcB/AluControl SHALL be latched into SrcA/SrcB/AluControl; state -> EXEC; matching Gnt high for cycle N+1 only.
REQ-019 Operands need be stable only at edge N; later changes SHALL not affect the op in flight.
REQ-020 In EXEC (cycle N+1), Req inputs SHALL be ignored; at edge N+1 AluResult is captured into the granted requester's Result, its Valid is high for cycle N+2 only, state -> IDLE.
REQ-021 Latency: Req sampled at edge N -> Gnt in cycle N+1 -> Valid/Result in cycle N+2; max throughput one op per 2 cycles.
REQ-022 A requester still holding Req at edge N+2 SHALL be treated as a new request (back-to-back allowed); round-robin then favours the other requester if also requesting.
REQ-023 Round-robin pointer SHALL update only on acceptance, never on idle cycles.
REQ-024 ResultX SHALL hold its value until the next completion for requester X; the other requester's Result is unaffected.
REQ-025 SrcA/SrcB/AluControl SHALL hold the last accepted values while IDLE.
REQ-026 At most one of Gnt0/Gnt1 and at most one of Valid0/Valid1 SHALL be high in any cycle.
REQ-027 Result is the 32-bit AluResult unmodified; no width change, no overflow handling.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, Gnt0/1=0, Valid0/1=0, Busy=0, Result0/1=0, SrcA=SrcB=0, AluControl=0, pointer so FIRST_PRI wins next tie.
REQ-029 Reset during EXEC SHALL abandon the op: no Valid pulse after release.
REQ-030 After rst_n deassertion, first acceptance may occur on the first clock edge with Req high.

Verification
REQ-031 Single: Req0=1, SrcA0=10, SrcB0=12, AluControl0=000 (add) at edge N -> Gnt0 cycle N+1, Busy=1, SrcA=10, SrcB=12; Valid0 cycle N+2, Result0=0x00000016; Result1 stays 0.
REQ-032 Tie after reset (FIRST_PRI=0): Req0=Req1=1 held -> grants alternate 0,1,0,1 on every second cycle; Valid pulses alternate accordingly.
REQ-033 Operand change: SrcA0 changed to 99 in cycle N+1 -> Result0 still computed from 10.
REQ-034 Reset mid-op: rst_n low in cycle N+1 -> all outputs 0 at once; no Valid0 after release.
REQ-035 Persistence: complete op on requester 1 (Result1=X), then 3 ops on requester 0 -> Result1 remains X throughout.
REQ-036 Invariant check every cycle: never Gnt0&Gnt1, never Valid0&Valid1, Busy high exactly one cycle per grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A request is
//   accepted in IDLE, its operands and op code are registered onto the shared
//   ALU bus, and one cycle later (EXEC) the ALU result is captured into that
//   requester's result register. Simultaneous requests are resolved
//   round-robin: the requester that was not granted most recently wins.
//
// Parameters
//   FIRST_PRI    requester (0/1) that wins a tie right after reset
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   Req0/Req1    request from requester 0 / 1
//   SrcA0/SrcB0  operands from requester 0
//   SrcA1/SrcB1  operands from requester 1
//   AluControl0/AluControl1  op codes from requester 0 / 1
//   Gnt0/Gnt1    one-cycle acceptance pulse (the EXEC cycle)
//   Valid0/Valid1 one-cycle result-valid pulse (the cycle after EXEC)
//   Result0/Result1 last completed result per requester
//   SrcA/SrcB    registered operands driven to the shared ALU
//   AluControl   registered op code driven to the shared ALU
//   AluResult    combinational result returned by the shared ALU
//   Busy         high while an operation is in EXEC
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned FIRST_PRI = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req0,
    input  logic        Req1,
    input  logic [31:0] SrcA0,
    input  logic [31:0] SrcB0,
    input  logic [31:0] SrcA1,
    input  logic [31:0] SrcB1,
    input  logic [2:0]  AluControl0,
    input  logic [2:0]  AluControl1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        Valid0,
    output logic        Valid1,
    output logic [31:0] Result0,
    output logic [31:0] Result1,
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  AluControl,
    input  logic [31:0] AluResult,
    output logic        Busy
);

    // Tie-break preference loaded at reset so FIRST_PRI wins the first tie.
    localparam logic C_RST_PREF = (FIRST_PRI != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_prefer;   // requester that wins the next tie
    logic        r_owner;    // requester whose op is in flight
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_valid0;
    logic        r_valid1;
    logic        r_busy;
    logic [31:0] r_result0;
    logic [31:0] r_result1;
    logic [31:0] r_srca;
    logic [31:0] r_srcb;
    logic [2:0]  r_aluctl;

    logic        w_any_req;
    logic        w_sel;      // 0 = requester 0, 1 = requester 1
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [2:0]  w_sel_ctl;

    // With a single request the requester id is simply Req1; only a tie
    // consults the round-robin preference.
    assign w_any_req = Req0 | Req1;
    assign w_sel     = (Req0 & Req1) ? r_prefer : Req1;
    assign w_sel_a   = w_sel ? SrcA1       : SrcA0;
    assign w_sel_b   = w_sel ? SrcB1       : SrcB0;
    assign w_sel_ctl = w_sel ? AluControl1 : AluControl0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_prefer  <= C_RST_PREF;
            r_owner   <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_valid0  <= 1'b0;
            r_valid1  <= 1'b0;
            r_busy    <= 1'b0;
            r_result0 <= '0;
            r_result1 <= '0;
            r_srca    <= '0;
            r_srcb    <= '0;
            r_aluctl  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Valid is a single-cycle pulse following EXEC.
                    r_valid0 <= 1'b0;
                    r_valid1 <= 1'b0;
                    if (w_any_req) begin
                        // Operands are captured here, so later input changes
                        // cannot disturb the op in flight.
                        r_srca   <= w_sel_a;
                        r_srcb   <= w_sel_b;
                        r_aluctl <= w_sel_ctl;
                        r_owner  <= w_sel;
                        r_gnt0   <= ~w_sel;
                        r_gnt1   <= w_sel;
                        r_busy   <= 1'b1;
                        // Pointer moves only on acceptance, never on idle.
                        r_prefer <= ~w_sel;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Requests are ignored here; only the owner's result
                    // register is written.
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                    r_busy <= 1'b0;
                    if (r_owner) begin
                        r_result1 <= AluResult;
                        r_valid1  <= 1'b1;
                    end else begin
                        r_result0 <= AluResult;
                        r_valid0  <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Gnt0       = r_gnt0;
    assign Gnt1       = r_gnt1;
    assign Valid0     = r_valid0;
    assign Valid1     = r_valid1;
    assign Busy       = r_busy;
    assign Result0    = r_result0;
    assign Result1    = r_result1;
    assign SrcA       = r_srca;
    assign SrcB       = r_srcb;
    assign AluControl = r_aluctl;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Drives alu_arbiter with directed and random requests, supplies a
//   behavioural ALU on the shared bus, and compares against a transaction
//   model that schedules grant/valid/result events by cycle number.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned FIRST_PRI = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Req0 = 1'b0;
    logic        Req1 = 1'b0;
    logic [31:0] SrcA0 = '0;
    logic [31:0] SrcB0 = '0;
    logic [31:0] SrcA1 = '0;
    logic [31:0] SrcB1 = '0;
    logic [2:0]  AluControl0 = '0;
    logic [2:0]  AluControl1 = '0;
    logic        Gnt0, Gnt1, Valid0, Valid1, Busy;
    logic [31:0] Result0, Result1, SrcA, SrcB, AluResult;
    logic [2:0]  AluControl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.FIRST_PRI(FIRST_PRI)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0(Req0), .Req1(Req1),
        .SrcA0(SrcA0), .SrcB0(SrcB0), .SrcA1(SrcA1), .SrcB1(SrcB1),
        .AluControl0(AluControl0), .AluControl1(AluControl1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Valid0(Valid0), .Valid1(Valid1),
        .Result0(Result0), .Result1(Result1),
        .SrcA(SrcA), .SrcB(SrcB), .AluControl(AluControl),
        .AluResult(AluResult), .Busy(Busy)
    );

    // Behavioural shared ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    assign AluResult = alu_f(SrcA, SrcB, AluControl);

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- transaction model ----------------
    // An accepted op at cycle k grants in cycle k, completes (valid/result)
    // in cycle k+1, and the arbiter is free again from cycle k+2.
    int unsigned cyc = 0;
    int unsigned m_due = 0;
    int unsigned m_free_at = 0;
    logic        m_pend = 1'b0;
    logic        m_who = 1'b0;
    logic        m_pref = (FIRST_PRI != 0);
    logic        m_gnt0 = 1'b0, m_gnt1 = 1'b0, m_val0 = 1'b0, m_val1 = 1'b0, m_busy = 1'b0;
    logic [31:0] m_srca = '0, m_srcb = '0, m_res0 = '0, m_res1 = '0, m_pres = '0;
    logic [2:0]  m_ctl = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0; m_pref = (FIRST_PRI != 0); m_free_at = 0;
            m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_val0 = 1'b0; m_val1 = 1'b0; m_busy = 1'b0;
            m_srca = '0; m_srcb = '0; m_ctl = '0; m_res0 = '0; m_res1 = '0;
        end else begin
            cyc++;
            m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_val0 = 1'b0; m_val1 = 1'b0; m_busy = 1'b0;
            if (m_pend && cyc == m_due) begin
                if (m_who) begin m_res1 = m_pres; m_val1 = 1'b1; end
                else       begin m_res0 = m_pres; m_val0 = 1'b1; end
                m_pend = 1'b0;
            end else if (cyc >= m_free_at && (Req0 || Req1)) begin
                m_who  = (Req0 && Req1) ? m_pref : Req1;
                m_pref = !m_who;
                m_srca = m_who ? SrcA1 : SrcA0;
                m_srcb = m_who ? SrcB1 : SrcB0;
                m_ctl  = m_who ? AluControl1 : AluControl0;
                m_pres = alu_f(m_srca, m_srcb, m_ctl);
                m_pend = 1'b1;
                m_due  = cyc + 1;
                m_free_at = cyc + 2;
                m_gnt0 = !m_who; m_gnt1 = m_who; m_busy = 1'b1;
            end
        end
    end

    logic [136:0] obs_v, exp_v;
    assign obs_v = {Gnt0, Gnt1, Valid0, Valid1, Busy, AluControl, SrcA, SrcB, Result0, Result1};
    assign exp_v = {m_gnt0, m_gnt1, m_val0, m_val1, m_busy, m_ctl, m_srca, m_srcb, m_res0, m_res1};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        Req0 = 1'b0; Req1 = 1'b0;
        tick(); tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs_v !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h want 0", obs_v);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs_v !== '0) begin
            n_errors++; $display("FAIL reset_idle_after_release: got %h want 0", obs_v);
        end
    endtask

    task automatic test_single();
        idle_inputs();
        Req0 = 1'b1; SrcA0 = 32'd10; SrcB0 = 32'd12; AluControl0 = 3'b000;
        tick();
        Req0 = 1'b0;
        SrcA0 = 32'd99;   // changed while the op is in flight
        n_checks++;
        if ({Gnt0, Gnt1, Busy, Valid0, SrcA, SrcB} !== {1'b1, 1'b0, 1'b1, 1'b0, 32'd10, 32'd12}) begin
            n_errors++;
            $display("FAIL single_grant: gnt0=%b gnt1=%b busy=%b valid0=%b srca=%0d srcb=%0d want 1 0 1 0 10 12",
                     Gnt0, Gnt1, Busy, Valid0, SrcA, SrcB);
        end
        tick();
        n_checks++;
        if ({Valid0, Valid1, Gnt0, Busy, Result0, Result1} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h16, 32'h0}) begin
            n_errors++;
            $display("FAIL single_result: valid0=%b valid1=%b gnt0=%b busy=%b res0=%h res1=%h want 1 0 0 0 00000016 00000000",
                     Valid0, Valid1, Gnt0, Busy, Result0, Result1);
        end
        tick();
        n_checks++;
        if ({Valid0, Result0, SrcA, SrcB, AluControl} !== {1'b0, 32'h16, 32'd10, 32'd12, 3'b000}) begin
            n_errors++;
            $display("FAIL single_hold: valid0=%b res0=%h srca=%0d srcb=%0d ctl=%0d want 0 00000016 10 12 0",
                     Valid0, Result0, SrcA, SrcB, AluControl);
        end
    endtask

    task automatic test_tie();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1;
        SrcA0 = 32'd5; SrcB0 = 32'd3; AluControl0 = 3'd1;
        SrcA1 = 32'd6; SrcB1 = 32'd9; AluControl1 = 3'd4;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({Gnt0, Gnt1, Valid0, Valid1, Busy} !==
                {(i % 4 == 0), (i % 4 == 2), (i % 4 == 1), (i % 4 == 3), (i % 2 == 0)}) begin
                n_errors++;
                $display("FAIL tie_alternate[%0d]: gnt=%b%b valid=%b%b busy=%b", i, Gnt0, Gnt1, Valid0, Valid1, Busy);
            end
        end
        n_checks++;
        if ({Result0, Result1} !== {32'd2, 32'd15}) begin
            n_errors++; $display("FAIL tie_results: got %h %h want 00000002 0000000f", Result0, Result1);
        end
        idle_inputs();
    endtask

    task automatic test_pointer_idle();
        idle_inputs();
        Req0 = 1'b1; tick(); Req0 = 1'b0; tick();
        for (int i = 0; i < 5; i++) tick();
        Req0 = 1'b1; Req1 = 1'b1;
        tick();
        n_checks++;
        if ({Gnt0, Gnt1} !== 2'b01) begin
            n_errors++; $display("FAIL pointer_after_gnt0: gnt=%b%b want 01", Gnt0, Gnt1);
        end
        Req0 = 1'b0; tick(); tick();          // Req1 alone: grant 1 completes
        Req0 = 1'b0; Req1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Req0 = 1'b1; Req1 = 1'b1;
        tick();
        n_checks++;
        if ({Gnt0, Gnt1} !== 2'b10) begin
            n_errors++; $display("FAIL pointer_after_gnt1: gnt=%b%b want 10", Gnt0, Gnt1);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        Req1 = 1'b1; SrcA1 = 32'd7; SrcB1 = 32'd8; AluControl1 = 3'd0;
        tick();
        Req1 = 1'b0;
        n_checks++;
        if (Gnt1 !== 1'b1) begin
            n_errors++; $display("FAIL midop_grant: gnt1=%b want 1", Gnt1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_v !== '0) begin
            n_errors++; $display("FAIL midop_async_clear: got %h want 0", obs_v);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({Valid0, Valid1, Result1, Busy} !== 35'd0) begin
                n_errors++;
                $display("FAIL midop_no_valid[%0d]: valid=%b%b res1=%h busy=%b want 0", i, Valid0, Valid1, Result1, Busy);
            end
        end
    endtask

    task automatic test_persistence();
        logic [31:0] x, e0;
        idle_inputs();
        Req1 = 1'b1; SrcA1 = rnd_op(); SrcB1 = rnd_op(); AluControl1 = 3'($urandom_range(0, 7));
        x = alu_f(SrcA1, SrcB1, AluControl1);
        tick(); Req1 = 1'b0; tick();
        n_checks++;
        if ({Valid1, Result1} !== {1'b1, x}) begin
            n_errors++; $display("FAIL persist_r1: valid1=%b res1=%h want 1 %h", Valid1, Result1, x);
        end
        for (int k = 0; k < 3; k++) begin
            Req0 = 1'b1; SrcA0 = rnd_op(); SrcB0 = rnd_op(); AluControl0 = 3'($urandom_range(0, 7));
            e0 = alu_f(SrcA0, SrcB0, AluControl0);
            tick();
            Req0 = 1'b0; SrcA0 = $urandom;
            n_checks++;
            if (Result1 !== x) begin
                n_errors++; $display("FAIL persist_hold_gnt[%0d]: res1=%h want %h", k, Result1, x);
            end
            tick();
            n_checks++;
            if ({Valid0, Valid1, Result0, Result1} !== {1'b1, 1'b0, e0, x}) begin
                n_errors++;
                $display("FAIL persist_r0[%0d]: valid=%b%b res0=%h res1=%h want 10 %h %h", k, Valid0, Valid1, Result0, Result1, e0, x);
            end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 400; i++) begin
            Req0 = ($urandom_range(0, 3) != 0);
            Req1 = ($urandom_range(0, 2) == 0);
            SrcA0 = rnd_op(); SrcB0 = rnd_op(); AluControl0 = 3'($urandom_range(0, 7));
            SrcA1 = rnd_op(); SrcB1 = rnd_op(); AluControl1 = 3'($urandom_range(0, 7));
            tick();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++; $display("FAIL random_model[%0d]: got %h want %h", i, obs_v, exp_v);
            end
            n_checks++;
            if ((Gnt0 && Gnt1) || (Valid0 && Valid1) || (Busy !== (Gnt0 | Gnt1))) begin
                n_errors++;
                $display("FAIL random_invariant[%0d]: gnt=%b%b valid=%b%b busy=%b", i, Gnt0, Gnt1, Valid0, Valid1, Busy);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_pointer_idle();
        test_reset_mid_op();
        test_persistence();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
